// File: rtl/sensors_filter.sv
// sensors_filter
// Averages the readings of opposite sensor pairs into a height estimate,
// then smooths successive estimates with a DEPTH-entry moving average.
// A pair is usable only when both of its sensors read nonzero; a sample
// with no usable pair is reported as a sensor error and leaves the
// filter untouched.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - a sample is offered on sensors
//   in_ready   - block is idle and will take a sample this cycle
//   sensors    - flat vector, sensor i at [i*WIDTH +: WIDTH]
//   win_clr    - restart the moving-average window at the next stored sample
//   height     - filtered height, registered
//   out_valid  - one-cycle pulse: a result (or an error) is ready
//   sensor_err - qualifies out_valid: the sample had no usable pair
module sensors_filter #(
  parameter int WIDTH    = 8,
  parameter int NUM_SENS = 4,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SENS*WIDTH-1:0] sensors,
  input  logic                      win_clr,
  output logic [WIDTH-1:0]          height,
  output logic                      out_valid,
  output logic                      sensor_err
);

  localparam int HALF = NUM_SENS / 2;
  localparam int SL   = $clog2(NUM_SENS);
  localparam int SSW  = WIDTH + SL;        // pair-sum width
  localparam int SW   = SSW + 1;           // dividend / quotient width
  localparam int CW   = SL + 1;            // sensor count width
  localparam int DW   = CW + 1;            // divisor width
  localparam int LD   = $clog2(DEPTH);
  localparam int AW   = WIDTH + LD;        // window sum width
  localparam int CNTW = $clog2(SW + 1);

  typedef enum logic [1:0] {IDLE, SUM, DIV, FILT} state_t;

  state_t                      state_reg;
  logic                        in_ready_reg;
  logic                        out_valid_reg;
  logic                        err_reg;
  logic [WIDTH-1:0]            height_reg;
  logic [NUM_SENS*WIDTH-1:0]   sample_reg;
  logic [SW:0]                 rem_reg;
  logic [SW-1:0]               quo_reg;
  logic [DW-1:0]               d_reg;
  logic [CNTW-1:0]             cnt_reg;
  logic                        preload_reg;
  logic [AW-1:0]               win_sum_reg;
  logic [WIDTH-1:0]            win_reg [DEPTH];

  // Pair qualification and summation on the latched sample.
  logic [SSW-1:0] sum_c;
  logic [CW-1:0]  cnt_c;
  logic [WIDTH-1:0] a_c, b_c;
  always_comb begin
    sum_c = '0;
    cnt_c = '0;
    a_c   = '0;
    b_c   = '0;
    for (int i = 0; i < HALF; i++) begin
      a_c = sample_reg[i*WIDTH +: WIDTH];
      b_c = sample_reg[(i+HALF)*WIDTH +: WIDTH];
      if (a_c != '0 && b_c != '0) begin
        sum_c = sum_c + SSW'(a_c) + SSW'(b_c);
        cnt_c = cnt_c + CW'(2);
      end
    end
  end

  // (2S + C) / (2C) is S/C rounded half-up with integer arithmetic.
  logic [SW-1:0] n_c;
  logic [DW-1:0] d_c;
  assign n_c = {sum_c, 1'b0} + SW'(cnt_c);
  assign d_c = {cnt_c, 1'b0};

  // Restoring division step: the dividend shifts out of quo_reg's MSB
  // into the partial remainder while quotient bits shift in at the LSB.
  logic [SW:0]   trial_c;
  logic          take_c;
  logic [SW:0]   rem_next;
  logic [SW-1:0] quo_next;
  assign trial_c  = {rem_reg[SW-1:0], quo_reg[SW-1]};
  assign take_c   = trial_c >= (SW+1)'(d_reg);
  assign rem_next = take_c ? trial_c - (SW+1)'(d_reg) : trial_c;
  assign quo_next = {quo_reg[SW-2:0], take_c};

  // Window update. A win_clr arriving on the FILT edge itself still
  // applies to the sample being filtered.
  logic [WIDTH-1:0] q_w;
  logic             preload_now;
  logic [AW-1:0]    win_sum_next;
  logic [AW:0]      round_c;
  assign q_w          = quo_reg[WIDTH-1:0];
  assign preload_now  = preload_reg | win_clr;
  assign win_sum_next = preload_now ? (AW'(q_w) << LD)
                                    : win_sum_reg - AW'(win_reg[DEPTH-1]) + AW'(q_w);
  assign round_c      = ({1'b0, win_sum_next} + (AW+1)'(DEPTH/2)) >> LD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      height_reg    <= '0;
      sample_reg    <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      d_reg         <= '0;
      cnt_reg       <= '0;
      preload_reg   <= 1'b1;
      win_sum_reg   <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      if (win_clr) preload_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sample_reg   <= sensors;
            in_ready_reg <= 1'b0;
            state_reg    <= SUM;
          end
        end
        SUM: begin
          if (cnt_c == '0) begin
            // Error: window, height and pending preload stay as they are.
            out_valid_reg <= 1'b1;
            err_reg       <= 1'b1;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            rem_reg   <= '0;
            quo_reg   <= n_c;
            d_reg     <= d_c;
            cnt_reg   <= '0;
            state_reg <= DIV;
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + CNTW'(1);
          if (cnt_reg == CNTW'(SW-1)) state_reg <= FILT;
        end
        FILT: begin
          win_sum_reg   <= win_sum_next;
          height_reg    <= round_c[WIDTH-1:0];
          preload_reg   <= 1'b0;
          out_valid_reg <= 1'b1;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Window entries: entry 0 is the newest quotient.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg[gi] <= '0;
        end else if (state_reg == FILT) begin
          if (preload_now) begin
            win_reg[gi] <= q_w;
          end else begin
            if (gi == 0) win_reg[gi] <= q_w;
            else         win_reg[gi] <= win_reg[(gi == 0) ? 0 : gi-1];
          end
        end
      end
    end
  endgenerate

  assign in_ready   = in_ready_reg;
  assign height     = height_reg;
  assign out_valid  = out_valid_reg;
  assign sensor_err = err_reg;

endmodule

// File: doc/sensors_filter.md
SENSORS_FILTER -- requirements
Module: sensors_filter

Interface
REQ-001 Parameter WIDTH, default 8, sensor and height width in bits (4..16).
REQ-002 Parameter NUM_SENS, default 4, sensor count; even, 2..16; sensor i and sensor i+NUM_SENS/2 form opposite pair i.
REQ-003 Parameter DEPTH, default 4, moving-average window length; power of 2, 1..16.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  sample offered on sensors.
REQ-007 in_ready  out  1  block can accept a sample.
REQ-008 sensors  in  NUM_SENS*WIDTH  flat sensor vector; sensor i at bits [i*WIDTH +: WIDTH].
REQ-009 win_clr  in  1  request window restart at next stored sample.
REQ-010 height  out  WIDTH  filtered height, registered.
REQ-011 out_valid  out  1  one-cycle pulse: result or error ready.
REQ-012 sensor_err  out  1  qualifies out_valid; no usable pair in sample.

Function
REQ-013 Sample accepted only on an edge with in_valid=1 and in_ready=1; sensors latched at that edge; later input changes have no effect on that sample.
REQ-014 FSM states IDLE, SUM, DIV, FILT; in_ready=1 only in IDLE.
REQ-015 IDLE->SUM on accept; otherwise stay IDLE.
REQ-016 SUM, 1 cycle: pair usable iff both members nonzero; S = sum of all sensors in usable pairs; C = 2 * usable pair count; S width WIDTH+clog2(NUM_SENS), no overflow.
REQ-017 SUM->IDLE when C=0: out_valid=1 and sensor_err=1 for exactly one cycle, 2 cycles after accept edge; height and window unchanged.
REQ-018 SUM->DIV when C>0: sequential restoring division, N=2*S+C by D=2*C, one quotient bit per cycle, SW=WIDTH+clog2(NUM_SENS)+1 cycles; quotient = round-half-up(S/C), fits WIDTH bits.
REQ-019 DIV->FILT after SW cycles; FILT, 1 cycle: shift quotient into DEPTH-entry window, window sum updated, height <= (window_sum + DEPTH/2) >> log2(DEPTH); DEPTH=1 passes quotient through.
REQ-020 FILT->IDLE; out_valid=1, sensor_err=0 for that one IDLE cycle; total latency SW+3 cycles from accept edge (14 at defaults); in_ready=1 in the same cycle, so back-to-back samples allowed.
REQ-021 First stored sample after reset, or after any win_clr, preloads all DEPTH entries with its quotient (height = quotient).
REQ-022 win_clr seen on any edge sets a pending-preload flag consumed by next FILT; win_clr at the FILT edge applies to that sample; error samples do not consume it.
REQ-023 in_valid while in_ready=0 is ignored, not queued.
REQ-024 sensor_err=0 whenever out_valid=0.

Reset
REQ-025 rst_n=0 immediately forces IDLE, height=0, out_valid=0, sensor_err=0, window entries 0, preload flag set; in_ready=1 once reset is released.
REQ-026 Reset during SUM/DIV/FILT abandons the sample; no out_valid for it after release.

Verification
REQ-027 Reset, sensors 10,11,12,13 -> out_valid 14 cycles after accept, height 12, sensor_err 0.
REQ-028 Then 20,20,20,20 -> window 12,12,12,20, height 14.
REQ-029 Sensors 0,20,12,21 (pair 0 unusable) -> quotient 21 (20.5 rounded up); window 12,12,20,21, height 16.
REQ-030 Sensors 0,0,5,5 -> out_valid and sensor_err 2 cycles after accept; height holds 16.
REQ-031 win_clr pulse, then 7,7,7,7 -> height 7; in_valid held high through DIV -> exactly one sample accepted per IDLE cycle.
REQ-032 rst_n low mid-DIV, then release -> height 0, no out_valid, next sample preloads window.
